// File: rtl/undo_ring_stack.sv
// LIFO undo buffer over a circular array; the top pointer wraps modulo DEPTH.
// Define UNDO_WRAP_EN so a push onto a full stack overwrites the oldest entry.
module undo_ring_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int ADDRW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [ADDRW:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDRW:0] FULL_COUNT = (ADDRW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDRW-1:0] top_ptr_q, top_ptr_d;
  logic [ADDRW:0]   count_q, count_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mem_we;
  logic [ADDRW-1:0] mem_waddr;
  logic [ADDRW-1:0] next_ptr;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_COUNT);
  assign next_ptr = top_ptr_q + ADDRW'(1);

  always_comb begin
    top_ptr_d   = top_ptr_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = next_ptr;
    if (clear) begin
      top_ptr_d = '0;
      count_d   = '0;
    end else if (push && pop) begin
      if (is_empty) begin
        mem_we      = 1'b1;
        top_ptr_d   = next_ptr;
        count_d     = count_q + (ADDRW+1)'(1);
        underflow_d = 1'b1;
      end else begin
        // Swap: the old top leaves on pop_data while its slot is reused.
        pop_data_d  = mem_q[top_ptr_q];
        pop_valid_d = 1'b1;
        mem_we      = 1'b1;
        mem_waddr   = top_ptr_q;
      end
    end else if (push) begin
      if (!is_full) begin
        mem_we    = 1'b1;
        top_ptr_d = next_ptr;
        count_d   = count_q + (ADDRW+1)'(1);
      end else begin
        overflow_d = 1'b1;
`ifdef UNDO_WRAP_EN
        mem_we    = 1'b1;
        top_ptr_d = next_ptr;
`endif
      end
    end else if (pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        pop_data_d  = mem_q[top_ptr_q];
        pop_valid_d = 1'b1;
        top_ptr_d   = top_ptr_q - ADDRW'(1);
        count_d     = count_q - (ADDRW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_ptr_q   <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_ptr_q   <= top_ptr_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= push_data;
    end
  end

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign top       = is_empty ? '0 : mem_q[top_ptr_q];

endmodule
